// File: rtl/calc_pkg.sv
// Shared definitions for the rate divider and the blocks that select its period:
// FSM state encoding, tick counter width and the standard output frequencies.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2
  } rd_state_t;

  localparam int unsigned TICK_COUNT_W = 16;

  localparam logic [31:0] FREQ_5M   = 32'd5_000_000;
  localparam logic [31:0] FREQ_2M5  = 32'd2_500_000;
  localparam logic [31:0] FREQ_1M25 = 32'd1_250_000;

  // Reload value for the down-counter; a period of 0 behaves as a period of 1.
  function automatic logic [31:0] reload_value(input logic [31:0] period);
    return (period == 32'd0) ? 32'd0 : period - 32'd1;
  endfunction

endpackage

// File: rtl/rate_divider.sv
// Rate divider: emits a one-cycle tick every eff_period clk cycles while enabled.
// Optional tick counter is built only when RATE_DIVIDER_TICK_COUNT_EN is defined.
//
// state | meaning
// IDLE  | stopped, counter zero, waiting for enable
// LOAD  | one cycle to load counter with eff_period-1
// COUNT | counting down; tick on the edge after counter reaches zero
module rate_divider
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        clear,
  input  logic [31:0] period,
  output logic        tick,
  output logic        running
`ifdef RATE_DIVIDER_TICK_COUNT_EN
  ,
  output logic [TICK_COUNT_W-1:0] tick_count
`endif
);

  rd_state_t   state;
  logic [31:0] counter;

  // Sequencing FSM with inline down-counter; tick and running are registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      counter <= 32'd0;
      tick    <= 1'b0;
      running <= 1'b0;
    end else if (clear) begin
      state   <= IDLE;
      counter <= 32'd0;
      tick    <= 1'b0;
      running <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tick    <= 1'b0;
          running <= 1'b0;
          if (enable) state <= LOAD;
        end
        LOAD: begin
          counter <= reload_value(period);
          tick    <= 1'b0;
          running <= 1'b1;
          state   <= COUNT;
        end
        COUNT: begin
          if (!enable) begin
            // Stopping wins over a pending wrap: no tick on the way out.
            state   <= IDLE;
            counter <= 32'd0;
            tick    <= 1'b0;
            running <= 1'b0;
          end else if (counter == 32'd0) begin
            // Period is only sampled here, so mid-count changes wait for the wrap.
            tick    <= 1'b1;
            counter <= reload_value(period);
          end else begin
            tick    <= 1'b0;
            counter <= counter - 32'd1;
          end
        end
        default: begin
          state   <= IDLE;
          counter <= 32'd0;
          tick    <= 1'b0;
          running <= 1'b0;
        end
      endcase
    end
  end

`ifdef RATE_DIVIDER_TICK_COUNT_EN
  // Count ticks on the same edge that raises tick; wraps naturally at the top.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_count <= '0;
    end else if (clear) begin
      tick_count <= '0;
    end else if (state == COUNT && enable && counter == 32'd0) begin
      tick_count <= tick_count + {{(TICK_COUNT_W-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_rate_divider.sv
module tb_rate_divider;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] period = 32'd4;
  logic        tick;
  logic        running;
`ifdef RATE_DIVIDER_TICK_COUNT_EN
  logic [15:0] tick_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rate_divider dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .clear(clear),
    .period(period),
    .tick(tick),
    .running(running)
`ifdef RATE_DIVIDER_TICK_COUNT_EN
    ,
    .tick_count(tick_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: tracks the absolute edge on which the next tick is due.
  typedef enum {M_IDLE, M_LOAD, M_COUNT} mmode_t;
  mmode_t      m_mode = M_IDLE;
  longint      cyc = 0;
  longint      next_tick = 0;
  logic        m_tick = 1'b0;
  logic        m_run = 1'b0;
  logic [15:0] m_cnt = 16'd0;

  function automatic longint effp(input logic [31:0] p);
    return (p == 32'd0) ? 64'd1 : longint'({32'd0, p});
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      m_mode = M_IDLE;
      m_tick = 1'b0;
      m_run  = 1'b0;
      m_cnt  = 16'd0;
    end else begin
      cyc++;
      m_tick = 1'b0;
      if (clear) begin
        m_mode = M_IDLE;
        m_cnt  = 16'd0;
      end else begin
        case (m_mode)
          M_IDLE: if (enable) m_mode = M_LOAD;
          M_LOAD: begin
            m_mode    = M_COUNT;
            next_tick = cyc + effp(period);
          end
          M_COUNT: begin
            if (!enable) m_mode = M_IDLE;
            else if (cyc == next_tick) begin
              m_tick    = 1'b1;
              m_cnt     = m_cnt + 16'd1;
              next_tick = cyc + effp(period);
            end
          end
          default: m_mode = M_IDLE;
        endcase
      end
      m_run = (m_mode == M_COUNT);
    end
    #1;
    check("model_tick", {31'd0, tick}, {31'd0, m_tick});
    check("model_running", {31'd0, running}, {31'd0, m_run});
`ifdef RATE_DIVIDER_TICK_COUNT_EN
    check("model_tick_count", {16'd0, tick_count}, {16'd0, m_cnt});
`endif
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_cnt(input string name, input logic [15:0] exp);
`ifdef RATE_DIVIDER_TICK_COUNT_EN
    check(name, {16'd0, tick_count}, {16'd0, exp});
`else
    if (exp === 16'hxxxx) $display("unreachable %s", name);
`endif
  endtask

  initial begin
    step(3);
    resetn = 1'b1;
    step(1);
    check("rst_tick", {31'd0, tick}, 32'd0);
    check("rst_running", {31'd0, running}, 32'd0);
    chk_cnt("rst_cnt", 16'd0);

    // period 4: ticks 5, 9, 13 edges after LOAD entry
    period = 32'd4; enable = 1'b1;
    step(1);
    check("p4_load_running", {31'd0, running}, 32'd0);
    for (int k = 1; k <= 14; k++) begin
      step(1);
      check("p4_tick", {31'd0, tick}, {31'd0, (k == 5 || k == 9 || k == 13)});
      check("p4_running", {31'd0, running}, 32'd1);
    end
    chk_cnt("p4_cnt", 16'd3);
    enable = 1'b0;
    step(1);
    check("stop_running", {31'd0, running}, 32'd0);
    step(3);
    chk_cnt("hold_cnt", 16'd3);

    // period 0 behaves as period 1
    clear = 1'b1; step(1); clear = 1'b0;
    chk_cnt("clr_cnt", 16'd0);
    period = 32'd0; enable = 1'b1;
    step(1);
    for (int k = 1; k <= 6; k++) begin
      step(1);
      check("p0_tick", {31'd0, tick}, {31'd0, (k >= 2)});
    end
    enable = 1'b0; step(1);

    // period 4 -> 2 two cycles after a tick
    period = 32'd4; enable = 1'b1;
    step(1);
    for (int k = 1; k <= 16; k++) begin
      step(1);
      check("chg_tick", {31'd0, tick},
            {31'd0, (k == 5 || k == 9 || k == 11 || k == 13 || k == 15)});
      if (k == 7) period = 32'd2;
    end
    enable = 1'b0; step(1);

    // clear on the cycle the counter is zero
    clear = 1'b1; step(1); clear = 1'b0;
    period = 32'd4; enable = 1'b1;
    step(1);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check("clr0_tick", {31'd0, tick}, {31'd0, (k == 5 || k == 9)});
    end
    chk_cnt("clr0_pre_cnt", 16'd2);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clr0_tick_after", {31'd0, tick}, 32'd0);
    check("clr0_running", {31'd0, running}, 32'd0);
    chk_cnt("clr0_cnt", 16'd0);
    step(1);
    check("clr0_reload_running", {31'd0, running}, 32'd0);
    step(1);
    check("clr0_count_running", {31'd0, running}, 32'd1);
    enable = 1'b0; step(1);

    // enable drops on the cycle the counter is zero
    enable = 1'b1; step(1);
    step(4);
    enable = 1'b0;
    step(1);
    check("en0_tick", {31'd0, tick}, 32'd0);
    check("en0_running", {31'd0, running}, 32'd0);

    // long periods: no tick soon, change to max period ignored mid-count
    period = FREQ_5M; enable = 1'b1;
    step(1);
    for (int k = 1; k <= 30; k++) begin
      step(1);
      check("long_tick", {31'd0, tick}, 32'd0);
      if (k == 10) period = 32'hFFFF_FFFF;
    end
    enable = 1'b0; step(1);
    enable = 1'b1;
    step(22);
    check("max_tick", {31'd0, tick}, 32'd0);
    check("max_running", {31'd0, running}, 32'd1);
    enable = 1'b0; step(1);

    // async reset mid-count while tick is high
    period = 32'd3; enable = 1'b1;
    step(1);
    step(4);
    check("rstmid_pre_tick", {31'd0, tick}, 32'd1);
    #1 resetn = 1'b0;
    #1;
    check("rstmid_tick", {31'd0, tick}, 32'd0);
    check("rstmid_running", {31'd0, running}, 32'd0);
    chk_cnt("rstmid_cnt", 16'd0);
    step(1);
    resetn = 1'b1;
    step(1);
    check("rstmid_load_running", {31'd0, running}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      step(1);
      check("rstmid_tick_after", {31'd0, tick}, {31'd0, (k == 4)});
      check("rstmid_running_after", {31'd0, running}, 32'd1);
    end
    enable = 1'b0; step(1);

`ifdef RATE_DIVIDER_TICK_COUNT_EN
    // 65537 ticks at period 1 wrap tick_count to 1
    clear = 1'b1; step(1); clear = 1'b0;
    period = 32'd1; enable = 1'b1;
    step(1);
    step(65538);
    check("wrap_tick", {31'd0, tick}, 32'd1);
    check("wrap_cnt", {16'd0, tick_count}, 32'h0000_0001);
    enable = 1'b0; step(1);
`endif

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
